// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   - register byte offsets on the handler's register port
//   - gateway state encoding
package irq_pkg;
  localparam logic [7:0] ENABLE    = 8'h00;
  localparam logic [7:0] PENDING   = 8'h04;
  localparam logic [7:0] THRESHOLD = 8'h08;
  localparam logic [7:0] CLAIM     = 8'h0C;
  localparam logic [7:0] PRIO_BASE = 8'h10;

  typedef enum logic [1:0] {IDLE, PEND, SERV} gw_state_e;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: word-addressed register port between the CPU handler and irq_ctrl.
//   reg_en/reg_we/reg_addr/reg_wdata : access request (handler -> controller)
//   reg_rdata/reg_rvalid             : registered read response (controller -> handler)
interface irq_ctrl_if;
  logic        reg_en;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;

  modport master (output reg_en, reg_we, reg_addr, reg_wdata,
                  input  reg_rdata, reg_rvalid);
  modport slave  (input  reg_en, reg_we, reg_addr, reg_wdata,
                  output reg_rdata, reg_rvalid);
endinterface

// File: rtl/irq_gateway.sv
// irq_gateway: per-source claim/complete gateway.
//   src      : sampled source level
//   claim    : this source won a CLAIM read this cycle
//   complete : COMPLETE written with this source's ID this cycle
//   pending  : gateway is in PEND
// A source in SERV ignores its level until completed, so a held line
// cannot flood the handler.
module irq_gateway
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending
);
  gw_state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (src)      state_nxt = PEND;
      PEND:    if (claim)    state_nxt = SERV;
      SERV:    if (complete) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  assign pending = (state == PEND);
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller.
//   clk, rst     : clock, asynchronous active-high reset
//   src_irq      : NSRC level-sensitive requests (ID i+1 = bit i)
//   bus          : register port (ENABLE, PENDING, THRESHOLD, CLAIM/COMPLETE, PRIORITY[i])
//   ex_interrupt : registered machine external interrupt request
// Build option IRQ_CTRL_SYNC_EN: adds a 2-flop synchronizer on every source.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src_irq,
  irq_ctrl_if.slave       bus,
  output logic            ex_interrupt
);
  localparam int ID_W = $clog2(NSRC + 1);

  logic [NSRC-1:0]             src_s, pending, claim, complete, enable;
  logic [PRIO_W-1:0]           threshold, best_prio;
  logic [NSRC-1:0][PRIO_W-1:0] prio;
  logic [ID_W-1:0]             best_id;
  logic [7:0]                  word_addr;
  logic                        rd, wr;
  logic [31:0]                 rdata_nxt;
  logic                        unused_addr;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync_q1, sync_q2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= src_irq;
      sync_q2 <= sync_q1;
    end
  assign src_s = sync_q2;
`else
  assign src_s = src_irq;
`endif

  assign word_addr   = {bus.reg_addr[7:2], 2'b00};
  assign unused_addr = ^bus.reg_addr[1:0];
  assign rd          = bus.reg_en & ~bus.reg_we;
  assign wr          = bus.reg_en &  bus.reg_we;

  // Configuration registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      enable    <= '0;
      threshold <= '0;
      prio      <= '0;
    end else if (wr) begin
      if (word_addr == ENABLE)    enable    <= bus.reg_wdata[NSRC-1:0];
      if (word_addr == THRESHOLD) threshold <= bus.reg_wdata[PRIO_W-1:0];
      for (int i = 0; i < NSRC; i++)
        if (word_addr == PRIO_BASE + 8'(4 * i)) prio[i] <= bus.reg_wdata[PRIO_W-1:0];
    end

  // Strict '>' keeps the lowest index on a tie; any candidate beats the
  // initial best_prio of 0 because it already exceeds the threshold.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NSRC; i++)
      if (pending[i] && enable[i] && prio[i] > threshold && prio[i] > best_prio) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio[i];
      end
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_gw
    assign claim[gi]    = rd && word_addr == CLAIM && best_id == ID_W'(gi + 1);
    assign complete[gi] = wr && word_addr == CLAIM && bus.reg_wdata == 32'(gi + 1);
    irq_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .src      (src_s[gi]),
      .claim    (claim[gi]),
      .complete (complete[gi]),
      .pending  (pending[gi])
    );
  end

  always_comb begin
    rdata_nxt = '0;
    case (word_addr)
      ENABLE:    rdata_nxt[NSRC-1:0]   = enable;
      PENDING:   rdata_nxt[NSRC-1:0]   = pending;
      THRESHOLD: rdata_nxt[PRIO_W-1:0] = threshold;
      CLAIM:     rdata_nxt[ID_W-1:0]   = best_id;
      default:
        for (int i = 0; i < NSRC; i++)
          if (word_addr == PRIO_BASE + 8'(4 * i)) rdata_nxt[PRIO_W-1:0] = prio[i];
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.reg_rdata  <= '0;
      bus.reg_rvalid <= 1'b0;
      ex_interrupt   <= 1'b0;
    end else begin
      bus.reg_rvalid <= rd;
      if (rd) bus.reg_rdata <= rdata_nxt;
      ex_interrupt <= (best_id != '0);
    end
endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src_irq = '0;
  logic       ex_interrupt;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] d;

  irq_ctrl_if bus ();

  irq_ctrl #(.NSRC(4), .PRIO_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_irq      (src_irq),
    .bus          (bus.slave),
    .ex_interrupt (ex_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.reg_en = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = v;
    @(posedge clk); #1;
    bus.reg_en = 1'b0; bus.reg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.reg_en = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = a;
    @(posedge clk); #1;
    bus.reg_en = 1'b0;
    check("rvalid", {31'd0, bus.reg_rvalid}, 32'd1);
    v = bus.reg_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic set_src(input logic [3:0] v);
    @(negedge clk);
    src_irq = v;
  endtask

  initial begin
    bus.reg_en = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex", {31'd0, ex_interrupt}, 32'd0);
    check("rst_rvalid", {31'd0, bus.reg_rvalid}, 32'd0);
    check("rst_rdata", bus.reg_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset values of every register
    rd_chk("r_enable", ENABLE, 0);
    rd_chk("r_pending", PENDING, 0);
    rd_chk("r_thresh", THRESHOLD, 0);
    rd_chk("r_claim", CLAIM, 0);
    for (int i = 0; i < 4; i++) rd_chk("r_prio", PRIO_BASE + 8'(4 * i), 0);
    tick();
    check("rvalid_pulse", {31'd0, bus.reg_rvalid}, 32'd0);
    check("r_ex", {31'd0, ex_interrupt}, 32'd0);

    // Upper write bits dropped, unmapped access, ignored low address bits
    wr(ENABLE, 32'hFF);    rd_chk("en_trunc", ENABLE, 32'hF);
    wr(THRESHOLD, 32'hFF); rd_chk("th_trunc", THRESHOLD, 32'h7);
    wr(8'h40, 32'h5);      rd_chk("unmapped", 8'h40, 0);
    wr(8'h0B, 32'h2);      rd_chk("addr_lsb", THRESHOLD, 32'h2);
    wr(ENABLE, 0); wr(THRESHOLD, 0);

    // Single-source round trip
    wr(PRIO_BASE + 8'h4, 2);
    wr(ENABLE, 32'h2);
    set_src(4'b0010);
    tick();
    check("ss_ex_t0", {31'd0, ex_interrupt}, 32'd0);
    tick();
    check("ss_ex_t1", {31'd0, ex_interrupt}, 32'd1);
    rd_chk("ss_pend", PENDING, 32'h2);
    rd_chk("ss_claim", CLAIM, 2);
    check("ss_ex_claim_edge", {31'd0, ex_interrupt}, 32'd1);
    tick();
    check("ss_ex_drop", {31'd0, ex_interrupt}, 32'd0);
    rd_chk("ss_pend_serv", PENDING, 0);
    wr(CLAIM, 2);
    check("ss_cmp_ex0", {31'd0, ex_interrupt}, 32'd0);
    tick();
    check("ss_cmp_ex1", {31'd0, ex_interrupt}, 32'd0);
    tick();
    check("ss_repend_ex", {31'd0, ex_interrupt}, 32'd1);
    rd_chk("ss_claim2", CLAIM, 2);
    set_src(4'b0000);
    wr(CLAIM, 2);
    tick();
    rd_chk("ss_idle", PENDING, 0);

    // Priority and tie-break: {3,5,5,1}
    wr(PRIO_BASE + 8'h0, 3); wr(PRIO_BASE + 8'h4, 5);
    wr(PRIO_BASE + 8'h8, 5); wr(PRIO_BASE + 8'hC, 1);
    wr(ENABLE, 32'hF);
    set_src(4'b1111);
    tick(); tick();
    rd_chk("pr_pend", PENDING, 32'hF);
    rd_chk("pr_c1", CLAIM, 2);
    rd_chk("pr_c2", CLAIM, 3);
    rd_chk("pr_c3", CLAIM, 1);
    rd_chk("pr_c4", CLAIM, 4);
    check("pr_ex_last", {31'd0, ex_interrupt}, 32'd1);
    rd_chk("pr_c_none", CLAIM, 0);
    check("pr_ex_none", {31'd0, ex_interrupt}, 32'd0);
    set_src(4'b0000);
    for (int i = 1; i <= 4; i++) wr(CLAIM, i);
    tick();
    rd_chk("pr_idle", PENDING, 0);

    // Invalid COMPLETE: source 1 in SERV, others IDLE
    set_src(4'b0001);
    tick();
    rd_chk("ic_claim", CLAIM, 1);
    wr(CLAIM, 0); wr(CLAIM, 7); wr(CLAIM, 2);
    tick();
    rd_chk("ic_pend", PENDING, 0);
    rd_chk("ic_claim0", CLAIM, 0);
    check("ic_ex", {31'd0, ex_interrupt}, 32'd0);
    wr(CLAIM, 1);
    tick();
    rd_chk("ic_repend", PENDING, 32'h1);
    rd_chk("ic_claim1", CLAIM, 1);
    set_src(4'b0000);
    wr(CLAIM, 1);

    // Threshold masking and enable gating (source 2, priority 5)
    wr(ENABLE, 32'h2);
    wr(THRESHOLD, 5);
    set_src(4'b0010);
    tick(); tick(); tick();
    check("th_block", {31'd0, ex_interrupt}, 32'd0);
    rd_chk("th_pend", PENDING, 32'h2);
    rd_chk("th_claim0", CLAIM, 0);
    wr(THRESHOLD, 4);
    check("th_wr_edge", {31'd0, ex_interrupt}, 32'd0);
    tick();
    check("th_open", {31'd0, ex_interrupt}, 32'd1);
    wr(ENABLE, 0);
    check("en_wr_edge", {31'd0, ex_interrupt}, 32'd1);
    tick();
    check("en_off", {31'd0, ex_interrupt}, 32'd0);
    rd_chk("en_off_pend", PENDING, 32'h2);
    wr(ENABLE, 32'h2);
    tick();
    check("en_on", {31'd0, ex_interrupt}, 32'd1);

    // Reset while in SERV, source held high
    rd_chk("rs_claim", CLAIM, 2);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rs_ex", {31'd0, ex_interrupt}, 32'd0);
    check("rs_rvalid", {31'd0, bus.reg_rvalid}, 32'd0);
    check("rs_rdata", bus.reg_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    rd_chk("rs_repend", PENDING, 32'h2);
    rd_chk("rs_enable", ENABLE, 0);
    rd_chk("rs_thresh", THRESHOLD, 0);
    rd_chk("rs_prio1", PRIO_BASE + 8'h4, 0);
    check("rs_ex_after", {31'd0, ex_interrupt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Platform interrupt controller that gathers `NSRC` external interrupt sources, gates each through a per-source claim/complete gateway, and drives the single machine external-interrupt line (`ex_interrupt`) into the CPU's CSR unit. The CPU's interrupt handler programs and services the block through a simple word-addressed register port. The handler reads CLAIM to get the winning source ID, then writes the same ID back to COMPLETE.

## Interface
- `NSRC`, default 4: number of interrupt sources, 1..31. Source IDs are 1..NSRC; ID 0 means "none".
- `PRIO_W`, default 3: priority field width. Priority 0 means never interrupt.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `src_irq`, in, NSRC: level-sensitive source requests, active-high.
- `reg_en`, in, 1: register access strobe, one access per cycle.
- `reg_we`, in, 1: 1 means write, 0 means read. Qualified by `reg_en`.
- `reg_addr`, in, 8: byte address, word aligned. Bits [1:0] are ignored.
- `reg_wdata`, in, 32: write data.
- `reg_rdata`, out, 32: read data, registered.
- `reg_rvalid`, out, 1: one-cycle pulse when `reg_rdata` is valid.
- `ex_interrupt`, out, 1: registered request to the CSR unit.

## Operation
- Register map:
  - 0x00 ENABLE, R/W, bits [NSRC-1:0].
  - 0x04 PENDING, RO, bits [NSRC-1:0]. Bit i corresponds to source ID i+1.
  - 0x08 THRESHOLD, R/W, [PRIO_W-1:0].
  - 0x0C CLAIM/COMPLETE: a read claims, a write completes.
  - 0x10+4*i PRIORITY[i], R/W, [PRIO_W-1:0].
  - Unmapped reads return 0. Unmapped writes are ignored. Unused upper write bits are dropped.
- Gateway FSM, one per source:
  - IDLE goes to PEND when the sampled `src_irq[i]` is 1.
  - PEND goes to SERV when source i is claimed.
  - SERV goes to IDLE when COMPLETE is written with ID i+1.
  - In SERV, source i cannot re-pend, whatever level it holds.
- The pending bit is 1 in PEND only. Disabling a source leaves its PEND state unchanged; it only removes the source from arbitration.
- Arbitration is combinational, over sources that are PEND, enabled, and have PRIORITY > THRESHOLD:
  - The highest priority wins.
  - On a tie, the lowest index wins.
  - The winner is `best_id`; it is 0 if there are no candidates.
- `ex_interrupt` is registered from (`best_id` != 0).
- CLAIM read:
  - Returns the `best_id` computed before the clock edge on which the access is sampled.
  - On that same edge, the winner moves PEND to SERV.
  - If `best_id` = 0, the read returns 0 and has no side effect.
- COMPLETE write:
  - An ID matching a source in SERV releases it to IDLE.
  - An ID of 0, out of range, or not in SERV is ignored.

## Timing
- Reset values:
  - All gateways IDLE.
  - ENABLE, THRESHOLD and every PRIORITY = 0.
  - `reg_rdata` = 0, `reg_rvalid` = 0, `ex_interrupt` = 0.
- Read latency: `reg_rvalid`/`reg_rdata` appear in the cycle after `reg_en`=1 with `reg_we`=0. Writes take effect at the sampling edge.
- Source to interrupt, without sync: `src_irq` high at edge t, PEND at t, `ex_interrupt` at t+1.
- A register write that changes arbitration, such as ENABLE or THRESHOLD, is reflected on `ex_interrupt` one edge after the write edge.
- After a CLAIM read, `ex_interrupt` drops one edge later, unless another candidate remains.
- COMPLETE while the source level is still high: IDLE at edge t, re-PEND at t+1.
- A source in IDLE that rises on the same edge as a CLAIM read is not claimable by that read.
- Reset asserted mid-service clears all state immediately, and the handler's pending claim is lost.

## Configuration
- `IRQ_CTRL_SYNC_EN`:
  - Defined: each `src_irq` bit passes through a 2-flop synchronizer before its gateway. This adds 2 cycles to source-to-interrupt latency (`ex_interrupt` at t+3).
  - Undefined: sources are sampled directly. Use this only when the sources are synchronous to `clk`.

## Structure
- `irq_pkg` holds:
  - register offset localparams (ENABLE, PENDING, THRESHOLD, CLAIM, PRIO_BASE);
  - the gateway state enum {IDLE, PEND, SERV}.
- Sub-module `irq_gateway`, instantiated NSRC times by generate:
  - Inputs: `src`, `claim`, `complete`.
  - Output: `pending`.
  - Contains one state register.
- The top level holds the configuration registers, the arbiter, the register port and the output flop.

## Test plan
- Reset, then read all registers: every read returns 0, `ex_interrupt`=0.
- Single-source round trip:
  - Set PRIORITY[1]=2, ENABLE=0x2, THRESHOLD=0, raise `src_irq[1]`.
  - Expect `ex_interrupt`=1 at the +1 edge; CLAIM reads 2; `ex_interrupt`=0 the next cycle.
  - Write COMPLETE=2 with the source still high: it re-pends and `ex_interrupt` rises again.
- Priority and tie-break:
  - PRIORITY = {3,5,5,1}, all four enabled and raised.
  - Successive claims return 2, 3, 1, 4.
- Threshold masking:
  - THRESHOLD=5 blocks priority 5, and `ex_interrupt` stays 0.
  - Write THRESHOLD=4: `ex_interrupt`=1 one edge later.
- Invalid COMPLETE:
  - Write IDs 0, 7, or an ID whose source is not in SERV: no state change.
  - Claim with nothing pending returns 0.
- Reset in SERV: all gateways return to IDLE, and a high source re-pends on the first edge after reset release.
